bmem_line_arbiter: RTL and testbench

- Shares the single 64-bit burst memory port (bmem) between the instruction cache and the data cache; each cache issues whole 256-bit line requests.
- Sequences 4-beat read and write bursts and reassembles read beats into a line.
- Sits between the core's cache pair and the bmem interface; at most one burst is outstanding.

---
 rtl/bmem_line_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bmem_line_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_line_arbiter.sv
// Shares one 64-bit burst memory port between the icache and dcache, one whole-line burst at a time.
// Optional build macro BMEM_ARB_RR_EN: round-robin read arbitration between the caches.
module bmem_line_arbiter #(
  parameter int LINE_BEATS  = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  // icache side
  input  logic [31:0]              i_addr,
  input  logic                     i_read,
  output logic [64*LINE_BEATS-1:0] i_rdata,
  output logic                     i_resp,
  // dcache side
  input  logic [31:0]              d_addr,
  input  logic                     d_read,
  input  logic                     d_write,
  input  logic [64*LINE_BEATS-1:0] d_wdata,
  output logic [64*LINE_BEATS-1:0] d_rdata,
  output logic                     d_resp,
  // burst memory side
  output logic [31:0]              bmem_addr,
  output logic                     bmem_read,
  output logic                     bmem_write,
  output logic [63:0]              bmem_wdata,
  input  logic                     bmem_ready,
  input  logic [31:0]              bmem_raddr,
  input  logic [63:0]              bmem_rdata,
  input  logic                     bmem_rvalid
);

  localparam int LINE_W = 64 * LINE_BEATS;
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_D_RD, GNT_I_RD} grant_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   i_line_q, i_line_d;
  logic [LINE_W-1:0]   d_line_q, d_line_d;
  logic [BEAT_W+5:0]   beat_lsb;
  logic                beat_accept;
  grant_e              grant;

`ifdef BMEM_ARB_RR_EN
  owner_e              last_grant_q, last_grant_d;
`endif

  assign beat_lsb    = {beat_q, 6'b0};
  assign beat_accept = (state_q == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);

  // Only meaningful while IDLE; a write beats any read, even an illegal d_read+d_write pair.
  always_comb begin
    grant = GNT_NONE;
    if (d_write)                 grant = GNT_WR;
`ifdef BMEM_ARB_RR_EN
    else if (d_read && i_read)   grant = (last_grant_q == OWN_D) ? GNT_I_RD : GNT_D_RD;
`endif
    else if (d_read)             grant = GNT_D_RD;
    else if (i_read)             grant = GNT_I_RD;
  end

`ifdef BMEM_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant == GNT_D_RD)      last_grant_d = OWN_D;
      else if (grant == GNT_I_RD) last_grant_d = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWN_I;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    // NOTE: every variable gets a hold default before the case, so no path can infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;

    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        unique case (grant)
          GNT_WR: begin
            owner_d = OWN_D;
            addr_d  = d_addr & ADDR_MASK;
            wline_d = d_wdata;
            state_d = WR_DATA;
          end
          GNT_D_RD: begin
            owner_d = OWN_D;
            addr_d  = d_addr & ADDR_MASK;
            state_d = RD_CMD;
          end
          GNT_I_RD: begin
            owner_d = OWN_I;
            addr_d  = i_addr & ADDR_MASK;
            state_d = RD_CMD;
          end
          default: state_d = IDLE;
        endcase
      end

      RD_CMD: begin
        if (bmem_ready) begin
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end

      // Beats tagged with another address belong to someone else and are dropped.
      RD_DATA: begin
        if (beat_accept) begin
          if (owner_q == OWN_D) d_line_d[beat_lsb +: 64] = bmem_rdata;
          else                  i_line_d[beat_lsb +: 64] = bmem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end

      WR_DATA: begin
        if (bmem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line buffers are cleared on reset because they are directly visible on i_rdata/d_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      beat_q   <= '0;
      addr_q   <= '0;
      wline_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
    end
  end

  assign bmem_addr  = addr_q;
  assign bmem_read  = (state_q == RD_CMD);
  assign bmem_write = (state_q == WR_DATA);
  assign bmem_wdata = (state_q == WR_DATA) ? wline_q[beat_lsb +: 64] : 64'd0;
  assign i_resp     = (state_q == RESP) && (owner_q == OWN_I);
  assign d_resp     = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rdata    = i_line_q;
  assign d_rdata    = d_line_q;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Self-checking bench for bmem_line_arbiter: directed steps plus randomized traffic against a line-level model.
// Honours BMEM_ARB_RR_EN when predicting which cache wins a read tie.
module tb_bmem_line_arbiter;

  localparam int LINE_BEATS = 4;
  localparam int LINE_W     = 64 * LINE_BEATS;
  localparam int CW         = LINE_W;
  localparam int BOUND      = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [63:0]       bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [63:0]       bmem_rdata;
  logic              bmem_rvalid;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;

  // Line-level reference model: last line returned to each cache, last read owner.
  logic [LINE_W-1:0] exp_i_line;
  logic [LINE_W-1:0] exp_d_line;
  bit                last_rd_d;

  bmem_line_arbiter #(.LINE_BEATS(LINE_BEATS), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bmem_read)  rd_cycles++;
    if (bmem_write) wr_cycles++;
    if (i_resp)     i_resp_cnt++;
    if (d_resp)     d_resp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic bit predict_d_first();
`ifdef BMEM_ARB_RR_EN
    return !last_rd_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic bmem_quiet();
    bmem_rvalid = 1'b0;
    bmem_raddr  = 32'h0;
    bmem_rdata  = 64'h0;
    bmem_ready  = 1'b1;
  endtask

  task automatic check_reset_state();
    check("rst_i_rdata", CW'(i_rdata), '0);
    check("rst_d_rdata", CW'(d_rdata), '0);
    check("rst_resp", CW'({i_resp, d_resp}), '0);
    check("rst_bmem_ctl", CW'({bmem_read, bmem_write}), '0);
    check("rst_bmem_addr", CW'(bmem_addr), '0);
    check("rst_bmem_wdata", CW'(bmem_wdata), '0);
  endtask

  // Entry: at a negedge with the DUT idle (or about to grant) and the owner's request raised.
  task automatic serve_read(input bit is_d, input logic [31:0] addr, input int cmd_stall,
                            input int stray_pct, input bit use_dead, input bit fixed_data);
    logic [31:0]       a;
    logic [LINE_W-1:0] expect_line;
    logic [31:0]       sent_addr[$];
    logic [63:0]       sent_data[$];
    int n, rd0, ir0, dr0, wr0, matched, guard, slot;
    bit dead_sent;
    a   = addr & 32'hFFFF_FFE0;
    rd0 = rd_cycles; wr0 = wr_cycles; ir0 = i_resp_cnt; dr0 = d_resp_cnt;
    n = 0;
    while (n == 0 || (!bmem_read && n < BOUND)) begin
      @(negedge clk);
      n++;
    end
    check(is_d ? "rd_d_grant_lat" : "rd_i_grant_lat", CW'(n), CW'(1));
    check("rd_cmd", CW'(bmem_read), CW'(1));
    check("rd_addr", CW'(bmem_addr), CW'(a));
    for (int s = 0; s < cmd_stall; s++) begin
      bmem_ready = 1'b0;
      @(negedge clk);
      check("rd_cmd_hold", CW'({bmem_read, bmem_addr}), CW'({1'b1, a}));
    end
    bmem_ready = 1'b1;
    @(negedge clk);
    check("rd_cmd_cycles", CW'(rd_cycles - rd0), CW'(cmd_stall + 1));
    check("rd_cmd_dropped", CW'(bmem_read), '0);

    matched = 0; guard = 0; dead_sent = 1'b0;
    while (matched < LINE_BEATS && guard < 8 * BOUND) begin
      guard++;
      bmem_rdata = {$urandom, $urandom};
      if (use_dead && matched == 2 && !dead_sent) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'hDEAD_0000;
        dead_sent   = 1'b1;
      end else if ($urandom_range(0, 99) < stray_pct) begin
        bmem_rvalid = 1'($urandom_range(0, 1));
        bmem_raddr  = a ^ (32'h20 << $urandom_range(0, 26));
      end else begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        if (fixed_data) bmem_rdata = 64'h1111_1111_1111_1111 * 64'(matched + 1);
        matched++;
      end
      if (bmem_rvalid) begin
        sent_addr.push_back(bmem_raddr);
        sent_data.push_back(bmem_rdata);
      end
      @(negedge clk);
      if (matched < LINE_BEATS) check("rd_no_early_resp", CW'({i_resp, d_resp}), '0);
    end
    bmem_quiet();

    // Model: the line is the matching beats in arrival order; everything else is dropped.
    expect_line = '0;
    slot = 0;
    foreach (sent_addr[j]) begin
      if (sent_addr[j] == a && slot < LINE_BEATS) begin
        expect_line[slot*64 +: 64] = sent_data[j];
        slot++;
      end
    end
    if (is_d) exp_d_line = expect_line;
    else      exp_i_line = expect_line;
    last_rd_d = is_d;

    check("rd_resp_owner", CW'({i_resp, d_resp}), CW'(is_d ? 2'b01 : 2'b10));
    check("rd_line_i", CW'(i_rdata), CW'(exp_i_line));
    check("rd_line_d", CW'(d_rdata), CW'(exp_d_line));
    if (is_d) d_read = 1'b0;
    else      i_read = 1'b0;
    @(negedge clk);
    check("rd_resp_single", CW'({i_resp, d_resp}), '0);
    check("rd_i_resp_cnt", CW'(i_resp_cnt - ir0), CW'(is_d ? 0 : 1));
    check("rd_d_resp_cnt", CW'(d_resp_cnt - dr0), CW'(is_d ? 1 : 0));
    check("rd_no_write", CW'(wr_cycles - wr0), '0);
    check("rd_hold_i", CW'(i_rdata), CW'(exp_i_line));
    check("rd_hold_d", CW'(d_rdata), CW'(exp_d_line));
  endtask

  // Entry: at a negedge with d_write/d_addr/d_wdata already raised and the DUT idle.
  task automatic serve_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                             input bit rand_stall, input int stall_beat, input int stall_len);
    logic [31:0]       a;
    logic [LINE_W-1:0] got;
    logic [63:0]       first;
    int n, want, total_stall, rd0, wr0, ir0, dr0;
    a = addr & 32'hFFFF_FFE0;
    rd0 = rd_cycles; wr0 = wr_cycles; ir0 = i_resp_cnt; dr0 = d_resp_cnt;
    got = '0; first = '0; total_stall = 0;
    n = 0;
    while (n == 0 || (!bmem_write && n < BOUND)) begin
      @(negedge clk);
      n++;
    end
    check("wr_grant_lat", CW'(n), CW'(1));
    for (int k = 0; k < LINE_BEATS; k++) begin
      want = rand_stall ? int'($urandom_range(0, 2)) : ((k == stall_beat) ? stall_len : 0);
      for (int s = 0; s <= want; s++) begin
        check("wr_valid", CW'(bmem_write), CW'(1));
        check("wr_addr", CW'(bmem_addr), CW'(a));
        check("wr_no_read", CW'(bmem_read), '0);
        if (s == 0) first = bmem_wdata;
        else        check("wr_hold", CW'(bmem_wdata), CW'(first));
        bmem_ready = (s == want);
        @(negedge clk);
      end
      got[k*64 +: 64] = first;
      total_stall += want;
    end
    bmem_ready = 1'b1;
    check("wr_beats", CW'(got), CW'(line));
    check("wr_cycles", CW'(wr_cycles - wr0), CW'(LINE_BEATS + total_stall));
    check("wr_resp", CW'({i_resp, d_resp, bmem_write}), CW'(3'b010));
    check("wr_d_rdata_kept", CW'(d_rdata), CW'(exp_d_line));
    d_write = 1'b0;
    @(negedge clk);
    check("wr_resp_single", CW'({i_resp, d_resp}), '0);
    check("wr_d_resp_cnt", CW'(d_resp_cnt - dr0), CW'(1));
    check("wr_i_resp_cnt", CW'(i_resp_cnt - ir0), '0);
    check("wr_read_cycles", CW'(rd_cycles - rd0), '0);
    check("wr_hold_i", CW'(i_rdata), CW'(exp_i_line));
  endtask

  task automatic idle_stray(input int cycles, input logic [31:0] raddr);
    int ir0, dr0;
    ir0 = i_resp_cnt; dr0 = d_resp_cnt;
    for (int c = 0; c < cycles; c++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = raddr;
      bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      check("stray_idle_ctl", CW'({bmem_read, bmem_write}), '0);
    end
    bmem_quiet();
    @(negedge clk);
    check("stray_no_resp", CW'((i_resp_cnt - ir0) + (d_resp_cnt - dr0)), '0);
    check("stray_i_line", CW'(i_rdata), CW'(exp_i_line));
    check("stray_d_line", CW'(d_rdata), CW'(exp_d_line));
  endtask

  task automatic tie_reads();
    logic [31:0] ia, da, dr;
    bit d_first;
    ia = $urandom;
    dr = $urandom;
    da = {~ia[31], dr[30:0]};
    d_first = predict_d_first();
    i_addr = ia; d_addr = da;
    i_read = 1'b1; d_read = 1'b1;
    serve_read(d_first, d_first ? da : ia, 0, 20, 1'b0, 1'b0);
    serve_read(!d_first, d_first ? ia : da, 0, 20, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0]       a;
    logic [LINE_W-1:0] line;
    int w0, ir0, dr0, n;

    rst = 1'b1;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_quiet();
    exp_i_line = '0; exp_d_line = '0; last_rd_d = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Stray beats while idle, tagged with the post-reset latched address.
    idle_stray(4, 32'h0);

    // Basic icache read with recognisable beat data.
    i_addr = 32'h0000_1234; i_read = 1'b1;
    serve_read(1'b0, 32'h0000_1234, 0, 0, 1'b0, 1'b1);
    check("tp_read_line", CW'(i_rdata),
          CW'({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));
    check("tp_read_addr", CW'(bmem_addr), CW'(32'h0000_1220));

    // Writeback with ready low for two cycles on the second beat.
    line = rand_line();
    d_addr = 32'h8000_0040; d_wdata = line; d_write = 1'b1;
    w0 = wr_cycles;
    serve_write(32'h8000_0040, line, 1'b0, 1, 2);
    check("tp_wr_cycles", CW'(wr_cycles - w0), CW'(6));

    // Stray beats while idle, tagged with the address just used.
    idle_stray(3, 32'h8000_0040);

    // d_read and d_write together: the write goes first, the read follows.
    line = rand_line();
    d_addr = 32'h0123_4560; d_wdata = line; d_write = 1'b1; d_read = 1'b1;
    serve_write(32'h0123_4560, line, 1'b0, 0, 0);
    serve_read(1'b1, 32'h0123_4560, 1, 0, 1'b0, 1'b0);

    // Foreign-tagged beat injected between matching beats.
    d_addr = 32'h0000_7F80; d_read = 1'b1;
    serve_read(1'b1, 32'h0000_7F80, 0, 0, 1'b1, 1'b0);

    // Read ties after an icache grant, then after a dcache grant.
    i_addr = 32'h0000_0A00; i_read = 1'b1;
    serve_read(1'b0, 32'h0000_0A00, 0, 0, 1'b0, 1'b0);
    tie_reads();
    d_addr = 32'h0000_0B00; d_read = 1'b1;
    serve_read(1'b1, 32'h0000_0B00, 0, 0, 1'b0, 1'b0);
    tie_reads();

    // Reset after two of four read beats; the late beats must be ignored.
    a = 32'h0000_5A40;
    i_addr = 32'h0000_5A5C; i_read = 1'b1;
    ir0 = i_resp_cnt; dr0 = d_resp_cnt;
    n = 0;
    while (n == 0 || (!bmem_read && n < BOUND)) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_cmd", CW'(bmem_read), CW'(1));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    bmem_quiet();
    rst = 1'b1; i_read = 1'b0;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = (k == 0) ? a : 32'h0; bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    bmem_quiet();
    @(negedge clk);
    exp_i_line = '0; exp_d_line = '0; last_rd_d = 1'b0;
    check("rst_mid_no_resp", CW'((i_resp_cnt - ir0) + (d_resp_cnt - dr0)), '0);
    check_reset_state();

    i_addr = 32'h0000_5A5C; i_read = 1'b1;
    serve_read(1'b0, 32'h0000_5A5C, 0, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 16; t++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          i_addr = a; i_read = 1'b1;
          serve_read(1'b0, a, $urandom_range(0, 2), 30, 1'b0, 1'b0);
        end
        1: begin
          d_addr = a; d_read = 1'b1;
          serve_read(1'b1, a, $urandom_range(0, 2), 30, 1'b0, 1'b0);
        end
        2: begin
          line = rand_line();
          d_addr = a; d_wdata = line; d_write = 1'b1;
          serve_write(a, line, 1'b1, 0, 0);
        end
        default: tie_reads();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
